// File: rtl/fdm_pkg.sv
// Shared constants and control-state encoding for the frequency / duty-cycle meter.
package fdm_pkg;

    localparam int DUTY_SCALE = 10000;
    localparam int NUM_W      = 40;
    localparam int DUTY_MAX   = 10000;
    // Wide enough to hold GATE_CYCLES up to 2^26 (and a full-window high count).
    localparam int DEN_W      = 27;
    localparam int ITER_W     = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } fdm_state_e;

endpackage

// File: rtl/fdm_divider.sv
// Restoring divider: one quotient bit per cycle, NUM_W iterations after start.
// done pulses for one cycle with the floor quotient on 'quotient'.
module fdm_divider
    import fdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    logic [DEN_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [DEN_W-1:0]  den_q, den_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DEN_W:0]    trial;

    // quo_q shifts the numerator out of its top while quotient bits enter at the bottom.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        trial  = {rem_q, quo_q[NUM_W-1]};
        if (start) begin
            rem_d  = '0;
            quo_d  = num;
            den_d  = den;
            iter_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, den_q}) begin
                rem_d = DEN_W'(trial - {1'b0, den_q});
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            if (iter_q == ITER_W'(NUM_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                iter_d = iter_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/freq_duty_meter.sv
// Gated edge counter with optional duty-cycle measurement (enabled by macro FDM_DUTY_EN).
// state  | meaning
// S_IDLE | waiting for a window to close
// S_DIV  | divider computing high_cnt*10000 / GATE_CYCLES
// S_DONE | one cycle, duty_data/duty_valid presented
module freq_duty_meter
    import fdm_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000
)
(
    input  logic        freq_source,
    input  logic        rst,
    input  logic        sig_in,
    output logic [31:0] freq_data,
    output logic        freq_valid,
    output logic [15:0] duty_data,
    output logic        duty_valid
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [31:0]       edge_cnt_q, edge_cnt_d;
    logic [31:0]       freq_data_q, freq_data_d;
    logic              freq_valid_q, freq_valid_d;
    logic              rise;
    logic              win_close;
    logic [31:0]       edge_final;

    // The closing cycle's own edge is folded into the reported count.
    always_comb begin
        s1_d       = sig_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        rise       = s2_q & ~s3_q;
        win_close  = (gate_cnt_q == GATE_LAST);
        edge_final = (rise && (edge_cnt_q != 32'hFFFF_FFFF)) ? edge_cnt_q + 32'd1 : edge_cnt_q;
        gate_cnt_d = win_close ? '0 : gate_cnt_q + 1'b1;
        edge_cnt_d = win_close ? '0 : edge_final;
        freq_data_d  = win_close ? edge_final : freq_data_q;
        freq_valid_d = win_close;
    end

    always_ff @(posedge freq_source) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            freq_data_q  <= '0;
            freq_valid_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            freq_data_q  <= freq_data_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    assign freq_data  = freq_data_q;
    assign freq_valid = freq_valid_q;

`ifdef FDM_DUTY_EN
    fdm_state_e       state_q, state_d;
    logic [DEN_W-1:0] high_cnt_q, high_cnt_d;
    logic [DEN_W-1:0] high_final;
    logic [15:0]      duty_data_q, duty_data_d;
    logic             duty_valid_q, duty_valid_d;
    logic             div_start, div_busy, div_done;
    logic [NUM_W-1:0] div_num, div_quo;

    always_comb begin
        high_final   = high_cnt_q + DEN_W'(s2_q);
        high_cnt_d   = win_close ? '0 : high_final;
        div_num      = NUM_W'(high_final) * NUM_W'(DUTY_SCALE);
        state_d      = state_q;
        duty_data_d  = duty_data_q;
        duty_valid_d = 1'b0;
        div_start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_close && !div_busy) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d      = S_DONE;
                    duty_valid_d = 1'b1;
                    duty_data_d  = (div_quo > NUM_W'(DUTY_MAX)) ? 16'(DUTY_MAX) : div_quo[15:0];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge freq_source) begin
        if (rst) begin
            state_q      <= S_IDLE;
            high_cnt_q   <= '0;
            duty_data_q  <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            duty_data_q  <= duty_data_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    fdm_divider u_div (
        .clk      (freq_source),
        .rst      (rst),
        .start    (div_start),
        .num      (div_num),
        .den      (DEN_W'(GATE_CYCLES)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign duty_data  = duty_data_q;
    assign duty_valid = duty_valid_q;
`else
    assign duty_data  = 16'd0;
    assign duty_valid = 1'b0;
`endif

endmodule

// File: doc/freq_duty_meter.md
FREQ_DUTY_METER -- requirements
Module: freq_duty_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50000000, gate window length in clock cycles; legal range 64..2^26.
REQ-002 Port freq_source  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port sig_in  in  1  asynchronous signal under measurement.
REQ-005 Port freq_data  out  32  rising-edge count of the last completed gate window.
REQ-006 Port freq_valid  out  1  one-cycle pulse: freq_data updated this cycle.
REQ-007 Port duty_data  out  16  high-time ratio of the last window, unit 0.01 % (0..10000).
REQ-008 Port duty_valid  out  1  one-cycle pulse: duty_data updated this cycle.

Function
REQ-009 sig_in SHALL pass a 2-FF synchronizer (s1, s2) plus one delay stage s3; rising edge = s2 & ~s3.
REQ-010 gate_cnt SHALL run 0..GATE_CYCLES-1 continuously and wrap to 0 with no dead cycles between windows.
REQ-011 edge_cnt SHALL increment on each detected edge; high_cnt SHALL increment on each cycle with s2 = 1.
REQ-012 When gate_cnt = GATE_CYCLES-1, the closing window SHALL include that cycle's contribution; edge_cnt and high_cnt restart at 0 next cycle.
REQ-013 On the cycle after window close, freq_data SHALL take the final edge count and freq_valid SHALL be 1 for exactly that cycle.
REQ-014 edge_cnt SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-015 Same cycle as freq_valid, the divider SHALL load numerator high_cnt*10000 (NUM_W = 40 bits) and denominator GATE_CYCLES.
REQ-016 Divider SHALL be restoring, one quotient bit per cycle, NUM_W iterations; duty_valid SHALL pulse exactly NUM_W+1 = 41 cycles after freq_valid.
REQ-017 duty_data SHALL be the floor quotient clamped to 10000.
REQ-018 Control FSM states: S_IDLE (after reset, before first window close), S_DIV (divider active), S_DONE (one cycle, drives duty_valid, returns to S_IDLE).
REQ-019 Transitions: S_IDLE -> S_DIV on window close; S_DIV -> S_DONE after NUM_W iterations; S_DONE -> S_IDLE.
REQ-020 Window close during S_DIV cannot occur (GATE_CYCLES >= 64 > 41); the block SHALL not support that case.
REQ-021 freq_data and duty_data SHALL hold their values between valid pulses.

Reset
REQ-022 While rst = 1, all outputs SHALL be 0, all counters and synchronizer flops 0, FSM in S_IDLE.
REQ-023 rst asserted during S_DIV SHALL abort the division; no duty_valid for that window.
REQ-024 The first window after rst release SHALL start at gate_cnt = 0 and last a full GATE_CYCLES cycles.

Configuration
REQ-025 Macro FDM_DUTY_EN defined: high_cnt, divider and FSM present as specified.
REQ-026 FDM_DUTY_EN undefined: high_cnt, divider and FSM omitted; duty_data tied to 16'd0 and duty_valid tied to 0; frequency path unchanged.

Structure
REQ-027 Shared package fdm_pkg SHALL hold DUTY_SCALE = 10000, NUM_W = 40, DUTY_MAX = 10000 and the FSM state encodings.
REQ-028 The divider SHALL be a sub-module fdm_divider (start/busy/done handshake, quotient out); synchronizer, counters and FSM stay in freq_duty_meter.

Verification (GATE_CYCLES = 1000; check the second and later windows)
REQ-029 sig_in period 10 cycles, 5 high -> freq_data = 100, duty_data = 5000, duty_valid 41 cycles after freq_valid.
REQ-030 sig_in period 20 cycles, 5 high -> freq_data = 50, duty_data = 2500.
REQ-031 sig_in constant 1 -> freq_data = 0, duty_data = 10000; constant 0 -> both 0.
REQ-032 rst pulsed for 3 cycles, starting 10 cycles after freq_valid -> no duty_valid, all outputs 0; next freq_valid exactly 1001 cycles after rst falls.
REQ-033 FDM_DUTY_EN undefined, period-10 stimulus -> freq_data = 100, duty_valid never asserted, duty_data = 0.
REQ-034 Checker: freq_valid and duty_valid are never high for two consecutive cycles, and duty_data <= 10000 at all times.
